lii_rx_buffer: RTL
==================

# lii_rx_buffer

Receive-side buffer for one LII physical input channel, directly upstream of a kernel's top wrapper. It takes flits from the LII network, keeps those addressed to this tile (or broadcast), and discards the rest. Kept flits go into a first-word-fall-through FIFO, which presents them on an LII-shaped output that drives the wrapper's `lii_in_p0_*` port. The FIFO decouples network back-pressure from kernel stalls, so the kernel clock enable is not starved by single-cycle bubbles.

## Interface
Parameters:
- `PW`, 128, flit data width in bits.
- `DEPTH`, 16, FIFO entries; must be a power of two, ≥ 2.
- `MY_ID`, 8'h00, LII destination ID of this tile.

Ports:
- `aclk`  in  1  sole clock; all logic rising-edge.
- `arst`  in  1  reset, synchronous, active-high.
- `lii_in_tdata`  in  PW  network flit payload.
- `lii_in_tvalid`  in  1  network flit valid.
- `lii_in_tready`  out  1  flit consumed (kept or dropped).
- `lii_in_src`  in  8  source ID.
- `lii_in_dst`  in  8  destination ID.
- `lii_out_tdata`  out  PW  buffered payload to the wrapper.
- `lii_out_tvalid`  out  1  head entry valid.
- `lii_out_tready`  in  1  wrapper accepts head.
- `lii_out_src`  out  8  head source ID.
- `lii_out_dst`  out  8  head destination ID.
- `fifo_level`  out  $clog2(DEPTH)+1  entries held.
- `drop_pulse`  out  1  one-cycle pulse per discarded flit.

## Operation
- Match: `lii_in_dst == MY_ID` or `lii_in_dst == 8'hFF` (broadcast).
- Matching flit:
  - `lii_in_tready = !full`, where full is `fifo_level == DEPTH`.
  - On handshake, push `{src, dst, tdata}` into the FIFO.
- Non-matching flit:
  - `lii_in_tready = 1` regardless of FIFO state; the flit is discarded.
  - `drop_pulse` is 1 on the following cycle.
- `lii_in_tready` may depend combinationally on `lii_in_tvalid` and `lii_in_dst` only, never on `lii_out_tready`.
- Output side:
  - `lii_out_tvalid = (fifo_level != 0)`.
  - `lii_out_*` show the head entry; they are registered or read straight from storage, with no combinational path from `lii_in_*`.
  - Pop occurs when `lii_out_tvalid && lii_out_tready`.
- Pointers are `$clog2(DEPTH)+1` bits with natural wrap. Full when the MSBs differ and the lower bits are equal; empty when the pointers are equal.
- `fifo_level` behaviour:
  - +1 on push only, −1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Never exceeds `DEPTH` and never underflows.
- Flit order is preserved; src, dst and data travel together unmodified.

## Timing
- Latency: a flit pushed into an empty FIFO in cycle N appears on `lii_out_tvalid` in cycle N+1. There is no same-cycle bypass.
- Throughput: one flit per cycle when neither side stalls.
- Full FIFO: `lii_in_tready = 0` for a matching flit even if a pop happens in the same cycle; it goes high the cycle after the pop.
- Empty FIFO with push and `lii_out_tready = 1` in the same cycle: no pop that cycle; the head is valid next cycle.
- Output stability: while `lii_out_tvalid && !lii_out_tready`, all `lii_out_*` stay stable.
- Reset (`arst` high at a clock edge), including mid-stream:
  - Pointers and `fifo_level` go to 0 and contents are flushed.
  - `lii_out_tvalid`, `lii_out_tdata`, `lii_out_src`, `lii_out_dst` and `drop_pulse` go to 0.
  - `lii_in_tready` is forced to 0 while `arst` is high.
  - Stats counters go to 0.

## Configuration
- `LII_RX_STATS_EN`
  - Defined: adds output ports `stat_accept_cnt` [31:0] and `stat_drop_cnt` [31:0]. They count matching pushes and discards respectively, saturate at 32'hFFFF_FFFF, and are cleared only by `arst`.
  - Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package `lii_pkg`:
  - `LII_ID_W = 8`.
  - `LII_BCAST_ID = 8'hFF`.
  - Packed typedef `lii_flit_t` holding `{src, dst, data}`, parameterised through `PW`.
- Sub-module `lii_fifo_sync`: a generic synchronous FWFT FIFO with width, depth, push, pop, full, empty and level. `lii_rx_buffer` adds the destination filter, drop pulse and stats around it.

## Test plan
- Reset, then a single flit with `dst = MY_ID`, `tdata = 128'hA5`, `src = 3`: `lii_out_tvalid` is high exactly 1 cycle after the handshake, with the same data, src = 3 and dst = `MY_ID`; `fifo_level` goes 0→1→0 on pop.
- Flits with `dst = 8'h07` (≠ `MY_ID`) and `dst = 8'hFF`: the first is consumed with `lii_in_tready = 1`, `drop_pulse` = 1 for exactly one cycle and no output; the broadcast flit appears on the output.
- Hold `lii_out_tready = 0` and send 20 matching flits with `DEPTH = 16`: `fifo_level` reaches 16 and `lii_in_tready` drops. Then release: all 20 flits come out in order with no loss or duplication.
- At full, assert pop while offering a matching flit: no push that cycle, `fifo_level` goes 16→15, and the push happens on the next cycle.
- Assert `arst` for 1 cycle with 5 flits buffered: the next cycle shows `fifo_level = 0` and `lii_out_tvalid = 0`, and no stale flit ever emerges.
- With `LII_RX_STATS_EN` defined: after 10 kept and 4 dropped flits, `stat_accept_cnt = 10` and `stat_drop_cnt = 4`.

Source files
------------

// File: rtl/lii_pkg.sv
// Shared LII definitions: ID width, broadcast ID, flit payload type and the
// destination-match helper used by receive-side blocks.
package lii_pkg;

    localparam int unsigned LII_ID_W = 8;
    localparam int unsigned LII_PW   = 128;

    localparam logic [LII_ID_W-1:0] LII_BCAST_ID = 8'hFF;

    // Default-width flit; blocks with a non-default PW declare the same layout locally.
    typedef struct packed {
        logic [LII_ID_W-1:0] src;
        logic [LII_ID_W-1:0] dst;
        logic [LII_PW-1:0]   data;
    } lii_flit_t;

    function automatic logic lii_dst_match(
        input logic [LII_ID_W-1:0] dst,
        input logic [LII_ID_W-1:0] my_id
    );
        return (dst == my_id) || (dst == LII_BCAST_ID);
    endfunction

endpackage

// File: rtl/lii_fifo_sync.sv
// Generic synchronous first-word-fall-through FIFO with wrap-bit pointers.
// The head entry is read straight from storage and forced to zero when empty.
module lii_fifo_sync #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = wr_ptr - rd_ptr;
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: pointer reset alone empties the FIFO.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/lii_rx_buffer.sv
// LII receive buffer: keeps flits for MY_ID or broadcast, drops the rest, and
// queues kept flits in an FWFT FIFO. Optional LII_RX_STATS_EN adds counters.
module lii_rx_buffer
    import lii_pkg::*;
#(
    parameter int unsigned          PW    = 128,
    parameter int unsigned          DEPTH = 16,
    parameter logic [LII_ID_W-1:0]  MY_ID = 8'h00
) (
    input  logic                     aclk,
    input  logic                     arst,
    input  logic [PW-1:0]            lii_in_tdata,
    input  logic                     lii_in_tvalid,
    output logic                     lii_in_tready,
    input  logic [LII_ID_W-1:0]      lii_in_src,
    input  logic [LII_ID_W-1:0]      lii_in_dst,
    output logic [PW-1:0]            lii_out_tdata,
    output logic                     lii_out_tvalid,
    input  logic                     lii_out_tready,
    output logic [LII_ID_W-1:0]      lii_out_src,
    output logic [LII_ID_W-1:0]      lii_out_dst,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     drop_pulse
`ifdef LII_RX_STATS_EN
    ,
    output logic [31:0]              stat_accept_cnt,
    output logic [31:0]              stat_drop_cnt
`endif
);

    typedef struct packed {
        logic [LII_ID_W-1:0] src;
        logic [LII_ID_W-1:0] dst;
        logic [PW-1:0]       data;
    } flit_t;

    flit_t wr_flit;
    flit_t rd_flit;
    logic  match;
    logic  full;
    logic  empty;
    logic  push;
    logic  pop;
    logic  drop;

    // tready looks only at dst and the registered full flag, never at the output side.
    assign match         = lii_dst_match(lii_in_dst, MY_ID);
    assign lii_in_tready = !arst && (!match || !full);
    assign push          = lii_in_tvalid && match && lii_in_tready;
    assign drop          = lii_in_tvalid && !match && !arst;
    assign pop           = lii_out_tvalid && lii_out_tready;

    assign wr_flit.src  = lii_in_src;
    assign wr_flit.dst  = lii_in_dst;
    assign wr_flit.data = lii_in_tdata;

    lii_fifo_sync #(
        .WIDTH ($bits(flit_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (aclk),
        .rst   (arst),
        .push  (push),
        .wdata (wr_flit),
        .pop   (pop),
        .rdata (rd_flit),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign lii_out_tvalid = !empty;
    assign lii_out_tdata  = rd_flit.data;
    assign lii_out_src    = rd_flit.src;
    assign lii_out_dst    = rd_flit.dst;

    always_ff @(posedge aclk) begin
        if (arst) begin
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= drop;
        end
    end

`ifdef LII_RX_STATS_EN
    localparam int unsigned STAT_W = 32;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge aclk) begin
        if (arst) begin
            stat_accept_cnt <= '0;
            stat_drop_cnt   <= '0;
        end else begin
            if (push && (stat_accept_cnt != '1)) begin
                stat_accept_cnt <= stat_accept_cnt + STAT_W'(1);
            end
            if (drop && (stat_drop_cnt != '1)) begin
                stat_drop_cnt <= stat_drop_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule
